// File: rtl/sb_pkg.sv
// sb_pkg: shared definitions for the sb_cfg_pipe switch-box tile.
//   - side indices in clockwise order (N, E, S, W)
//   - 2-bit select codes used by every output bit's mux
//   - configuration loader state encoding
//   - cfg_size(): length of the configuration image for a given track count
//     (two select bits per output bit on four sides, plus one mode bit per side)
package sb_pkg;

    localparam int SIDE_N = 0;
    localparam int SIDE_E = 1;
    localparam int SIDE_S = 2;
    localparam int SIDE_W = 3;

    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_CW1  = 2'd1;
    localparam logic [1:0] SEL_CW2  = 2'd2;
    localparam logic [1:0] SEL_CW3  = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        LOAD   = 3'd2,
        COMMIT = 3'd3,
        SKIP   = 3'd4
    } loader_state_t;

    function automatic int cfg_size(input int chn_width);
        return 8 * chn_width + 4;
    endfunction

endpackage

// File: rtl/sb_cfg_pipe_cfg_loader.sv
// cfg_loader: serial configuration loader for one switch-box tile.
// A frame is a start strobe, an ID_WIDTH-bit header (MSB first) and, when the
// header matches ID, CFG_SIZE payload bits shifted into a shadow register.
// The shadow is copied into the active register in a single COMMIT cycle, so
// routing changes atomically. The three chain inputs are re-registered
// unconditionally so downstream tiles see every frame one cycle later.
// Ports:
//   clk, crst                 clock, synchronous active-high reset
//   cfg_in_start              frame start strobe (restarts the loader)
//   cfg_bit_in                serial data
//   cfg_bit_in_valid          qualifies cfg_bit_in
//   cfg_out_start/bit/valid   registered copies of the three chain inputs
//   cfg_done                  one-cycle pulse while active is being updated
//   active                    current configuration image
module cfg_loader
    import sb_pkg::*;
#(
    parameter int CFG_SIZE = 132,
    parameter int ID_WIDTH = 3,
    parameter int ID       = 7
) (
    input  logic                clk,
    input  logic                crst,
    input  logic                cfg_in_start,
    input  logic                cfg_bit_in,
    input  logic                cfg_bit_in_valid,
    output logic                cfg_out_start,
    output logic                cfg_bit_out,
    output logic                cfg_bit_out_valid,
    output logic                cfg_done,
    output logic [CFG_SIZE-1:0] active
);

    localparam int CNT_W = $clog2(CFG_SIZE + 1);
    localparam logic [CNT_W-1:0]    HDR_LAST  = CNT_W'(ID_WIDTH - 1);
    localparam logic [CNT_W-1:0]    LOAD_LAST = CNT_W'(CFG_SIZE - 1);
    localparam logic [ID_WIDTH-1:0] MY_ID     = ID_WIDTH'(ID);

    loader_state_t       state;
    loader_state_t       state_next;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ID_WIDTH-1:0] id_sr;
    logic [ID_WIDTH-1:0] id_next;
    logic [CFG_SIZE-1:0] shadow;

    // Header value including the bit arriving this cycle, so the ID compare
    // can be made on the same edge that consumes the last header bit.
    assign id_next = ID_WIDTH'({id_sr, cfg_bit_in});

    always_ff @(posedge clk) begin
        if (crst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start strobe overrides everything, including a pending COMMIT, so an
    // interrupted or superseded frame never reaches the active register.
    always_comb begin
        state_next = state;
        cfg_done   = 1'b0;
        if (cfg_in_start) begin
            state_next = HDR;
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                HDR: begin
                    if (cfg_bit_in_valid && bit_cnt == HDR_LAST) begin
                        state_next = (id_next == MY_ID) ? LOAD : SKIP;
                    end
                end
                LOAD: begin
                    if (cfg_bit_in_valid && bit_cnt == LOAD_LAST) begin
                        state_next = COMMIT;
                    end
                end
                COMMIT: begin
                    cfg_done   = 1'b1;
                    state_next = IDLE;
                end
                SKIP:    state_next = SKIP;
                default: state_next = IDLE;
            endcase
        end
    end

    // The counter is cleared when the header completes so the payload count
    // starts from zero; in LOAD it stops at CFG_SIZE because the FSM leaves.
    always_ff @(posedge clk) begin
        if (crst) begin
            id_sr   <= '0;
            bit_cnt <= '0;
            shadow  <= '0;
            active  <= '0;
        end else if (cfg_in_start) begin
            id_sr   <= '0;
            bit_cnt <= '0;
            shadow  <= '0;
        end else begin
            case (state)
                HDR: begin
                    if (cfg_bit_in_valid) begin
                        id_sr   <= id_next;
                        bit_cnt <= (bit_cnt == HDR_LAST) ? '0 : bit_cnt + CNT_W'(1);
                    end
                end
                LOAD: begin
                    if (cfg_bit_in_valid) begin
                        shadow  <= {shadow[CFG_SIZE-2:0], cfg_bit_in};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                COMMIT: begin
                    active  <= shadow;
                    bit_cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Chain forwarding ignores the loader state entirely.
    always_ff @(posedge clk) begin
        if (crst) begin
            cfg_out_start     <= 1'b0;
            cfg_bit_out       <= 1'b0;
            cfg_bit_out_valid <= 1'b0;
        end else begin
            cfg_out_start     <= cfg_in_start;
            cfg_bit_out       <= cfg_bit_in;
            cfg_bit_out_valid <= cfg_bit_in_valid;
        end
    end

endmodule

// File: rtl/sb_cfg_pipe.sv
// sb_cfg_pipe: four-sided switch box with integrated serial config loader.
// Each output bit i of side s picks bit i of side (s+1)%4, (s+2)%4, (s+3)%4
// or constant 0, under a 2-bit select held in the active configuration.
// Each side can be registered (mode bit set) when REG_OUT_EN is nonzero.
// Ports:
//   clk, crst                                clock, sync active-high reset
//   north_in/east_in/south_in/west_in        side inputs
//   north_out/east_out/south_out/west_out    side outputs
//   cfg_in_start, cfg_bit_in, cfg_bit_in_valid      config chain inputs
//   cfg_out_start, cfg_bit_out, cfg_bit_out_valid   config chain outputs
//   cfg_done                                 pulse when active config updates
module sb_cfg_pipe
    import sb_pkg::*;
#(
    parameter int CHN_WIDTH  = 16,
    parameter int ID_WIDTH   = 3,
    parameter int ID         = 7,
    parameter int REG_OUT_EN = 1
) (
    input  logic                 clk,
    input  logic                 crst,
    input  logic [CHN_WIDTH-1:0] north_in,
    input  logic [CHN_WIDTH-1:0] east_in,
    input  logic [CHN_WIDTH-1:0] south_in,
    input  logic [CHN_WIDTH-1:0] west_in,
    output logic [CHN_WIDTH-1:0] north_out,
    output logic [CHN_WIDTH-1:0] east_out,
    output logic [CHN_WIDTH-1:0] south_out,
    output logic [CHN_WIDTH-1:0] west_out,
    input  logic                 cfg_in_start,
    input  logic                 cfg_bit_in,
    input  logic                 cfg_bit_in_valid,
    output logic                 cfg_out_start,
    output logic                 cfg_bit_out,
    output logic                 cfg_bit_out_valid,
    output logic                 cfg_done
);

    localparam int CFG_SIZE = cfg_size(CHN_WIDTH);
    localparam int MODE_LSB = 8 * CHN_WIDTH;

    logic [CFG_SIZE-1:0]              active;
    logic [3:0][CHN_WIDTH-1:0]        side_in;
    logic [3:0][CHN_WIDTH-1:0]        mux_out;
    logic [3:0][CHN_WIDTH-1:0]        side_out;

    assign side_in[SIDE_N] = north_in;
    assign side_in[SIDE_E] = east_in;
    assign side_in[SIDE_S] = south_in;
    assign side_in[SIDE_W] = west_in;

    assign north_out = side_out[SIDE_N];
    assign east_out  = side_out[SIDE_E];
    assign south_out = side_out[SIDE_S];
    assign west_out  = side_out[SIDE_W];

    cfg_loader #(
        .CFG_SIZE (CFG_SIZE),
        .ID_WIDTH (ID_WIDTH),
        .ID       (ID)
    ) u_loader (
        .clk               (clk),
        .crst              (crst),
        .cfg_in_start      (cfg_in_start),
        .cfg_bit_in        (cfg_bit_in),
        .cfg_bit_in_valid  (cfg_bit_in_valid),
        .cfg_out_start     (cfg_out_start),
        .cfg_bit_out       (cfg_bit_out),
        .cfg_bit_out_valid (cfg_bit_out_valid),
        .cfg_done          (cfg_done),
        .active            (active)
    );

    // One 4:1 mux per output bit; the source sides are fixed per output side
    // because the select codes count clockwise from the output side.
    for (genvar s = 0; s < 4; s++) begin : g_side
        for (genvar i = 0; i < CHN_WIDTH; i++) begin : g_bit
            logic [1:0] sel;
            logic       bit_val;

            assign sel = active[2*CHN_WIDTH*s + 2*i +: 2];

            always_comb begin
                bit_val = 1'b0;
                case (sel)
                    SEL_ZERO: bit_val = 1'b0;
                    SEL_CW1:  bit_val = side_in[(s+1)%4][i];
                    SEL_CW2:  bit_val = side_in[(s+2)%4][i];
                    SEL_CW3:  bit_val = side_in[(s+3)%4][i];
                    default:  bit_val = 1'b0;
                endcase
            end

            assign mux_out[s][i] = bit_val;
        end
    end

    // The output flops track the mux every cycle regardless of mode, so a
    // switch into registered mode shows last cycle's mux value immediately.
    if (REG_OUT_EN != 0) begin : g_reg
        logic [3:0][CHN_WIDTH-1:0] out_q;

        always_ff @(posedge clk) begin
            if (crst) begin
                out_q <= '0;
            end else begin
                out_q <= mux_out;
            end
        end

        for (genvar r = 0; r < 4; r++) begin : g_sel
            assign side_out[r] = active[MODE_LSB + r] ? out_q[r] : mux_out[r];
        end
    end else begin : g_comb
        logic unused_mode;
        assign unused_mode = ^active[MODE_LSB +: 4];
        assign side_out    = mux_out;
    end

endmodule

// File: tb/tb_sb_cfg_pipe.sv
// tb_sb_cfg_pipe: randomized self-checking bench for sb_cfg_pipe.
// Two instances share all inputs: one with output flops, one without.
// Expected outputs come from a frame-level model of the configuration image
// and a direct evaluation of each output bit's routing rule.
module tb_sb_cfg_pipe;

    localparam int CW   = 4;
    localparam int IDW  = 3;
    localparam int MYID = 5;
    localparam int CFG  = 8 * CW + 4;

    logic clk;
    logic crst;
    logic cfg_in_start, cfg_bit_in, cfg_bit_in_valid;
    logic [CW-1:0] north_in, east_in, south_in, west_in;
    logic [3:0][CW-1:0] out_r, out_c;
    logic start_r, bit_r, valid_r, done_r;
    logic start_c, bit_c, valid_c, done_c;

    int total = 0;
    int bad = 0;
    int done_seen = 0;

    logic [CFG-1:0] model_active;
    logic [CFG-1:0] staged_cfg;
    logic [3:0][CW-1:0] model_reg;
    logic commit_pending;
    logic prev_start, prev_bit, prev_valid;
    bit rand_sides;

    sb_cfg_pipe #(.CHN_WIDTH(CW), .ID_WIDTH(IDW), .ID(MYID), .REG_OUT_EN(1)) dut_r (
        .clk(clk), .crst(crst),
        .north_in(north_in), .east_in(east_in), .south_in(south_in), .west_in(west_in),
        .north_out(out_r[0]), .east_out(out_r[1]), .south_out(out_r[2]), .west_out(out_r[3]),
        .cfg_in_start(cfg_in_start), .cfg_bit_in(cfg_bit_in), .cfg_bit_in_valid(cfg_bit_in_valid),
        .cfg_out_start(start_r), .cfg_bit_out(bit_r), .cfg_bit_out_valid(valid_r),
        .cfg_done(done_r)
    );

    sb_cfg_pipe #(.CHN_WIDTH(CW), .ID_WIDTH(IDW), .ID(MYID), .REG_OUT_EN(0)) dut_c (
        .clk(clk), .crst(crst),
        .north_in(north_in), .east_in(east_in), .south_in(south_in), .west_in(west_in),
        .north_out(out_c[0]), .east_out(out_c[1]), .south_out(out_c[2]), .west_out(out_c[3]),
        .cfg_in_start(cfg_in_start), .cfg_bit_in(cfg_bit_in), .cfg_bit_in_valid(cfg_bit_in_valid),
        .cfg_out_start(start_c), .cfg_bit_out(bit_c), .cfg_bit_out_valid(valid_c),
        .cfg_done(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [3:0][CW-1:0] curIns();
        logic [3:0][CW-1:0] ins;
        ins[0] = north_in;
        ins[1] = east_in;
        ins[2] = south_in;
        ins[3] = west_in;
        return ins;
    endfunction

    // Routing rule: code 0 gives zero, code k takes side (s+k)%4, same bit.
    function automatic logic [CW-1:0] modelSide(input int s, input logic [CFG-1:0] cfg,
                                               input logic [3:0][CW-1:0] ins);
        logic [CW-1:0] r;
        int code;
        r = '0;
        for (int i = 0; i < CW; i++) begin
            code = int'(cfg[8*s + 2*i +: 2]);
            if (code != 0) r[i] = ins[(s + code) % 4][i];
        end
        return r;
    endfunction

    task automatic checkCycle();
        logic [3:0][CW-1:0] ins;
        logic [CW-1:0] mux;
        logic exp_done;
        ins = curIns();
        exp_done = commit_pending && !cfg_in_start;
        checkOutput("done_reg", done_r, exp_done);
        checkOutput("done_comb", done_c, exp_done);
        checkOutput("fwd_start", start_r, prev_start);
        checkOutput("fwd_bit", bit_r, prev_bit);
        checkOutput("fwd_valid", valid_r, prev_valid);
        checkOutput("fwd_start_c", start_c, prev_start);
        for (int s = 0; s < 4; s++) begin
            mux = modelSide(s, model_active, ins);
            checkOutput($sformatf("side%0d_reg", s), out_r[s],
                        model_active[8*CW + s] ? model_reg[s] : mux);
            checkOutput($sformatf("side%0d_comb", s), out_c[s], mux);
        end
    endtask

    // One clock cycle: drive, check mid-cycle, then advance the model past the edge.
    task automatic applyStimulus(input logic st, input logic b, input logic v);
        logic [3:0][CW-1:0] next_reg;
        logic do_commit;
        cfg_in_start = st;
        cfg_bit_in = b;
        cfg_bit_in_valid = v;
        if (rand_sides) begin
            north_in = CW'($urandom);
            east_in  = CW'($urandom);
            south_in = CW'($urandom);
            west_in  = CW'($urandom);
        end
        @(negedge clk);
        checkCycle();
        if (done_r === 1'b1) done_seen++;
        for (int s = 0; s < 4; s++) next_reg[s] = modelSide(s, model_active, curIns());
        do_commit = commit_pending && !st;
        @(posedge clk);
        #1;
        model_reg = next_reg;
        prev_start = st;
        prev_bit = b;
        prev_valid = v;
        if (do_commit) model_active = staged_cfg;
        commit_pending = 1'b0;
    endtask

    task automatic applyReset();
        crst = 1'b1;
        cfg_in_start = 1'b1;
        cfg_bit_in = 1'b1;
        cfg_bit_in_valid = 1'b1;
        north_in = 4'hF;
        east_in = 4'hA;
        south_in = 4'h5;
        west_in = 4'hC;
        repeat (2) @(posedge clk);
        #1;
        model_active = '0;
        model_reg = '0;
        commit_pending = 1'b0;
        prev_start = 1'b0;
        prev_bit = 1'b0;
        prev_valid = 1'b0;
        @(negedge clk);
        checkCycle();
        crst = 1'b0;
        cfg_in_start = 1'b0;
        cfg_bit_in = 1'b0;
        cfg_bit_in_valid = 1'b0;
        @(posedge clk);
        #1;
        model_reg = '0;
    endtask

    task automatic gapCycles(input int gap_pct);
        for (int g = 0; g < 3; g++) begin
            if (int'($urandom_range(99)) < gap_pct) applyStimulus(1'b0, 1'($urandom), 1'b0);
        end
    endtask

    task automatic sendFrame(input logic [IDW-1:0] fid, input logic [CFG-1:0] payload,
                             input int nbits, input int gap_pct, input int trail);
        applyStimulus(1'b1, 1'($urandom), 1'b1);
        for (int i = IDW - 1; i >= 0; i--) begin
            gapCycles(gap_pct);
            applyStimulus(1'b0, fid[i], 1'b1);
        end
        for (int j = 0; j < nbits; j++) begin
            gapCycles(gap_pct);
            applyStimulus(1'b0, payload[CFG-1-j], 1'b1);
        end
        if (fid == IDW'(MYID) && nbits >= CFG) begin
            staged_cfg = payload;
            commit_pending = 1'b1;
        end
        for (int t = 0; t < trail; t++) applyStimulus(1'b0, 1'($urandom), 1'($urandom));
    endtask

    function automatic logic [CFG-1:0] randCfg();
        logic [63:0] w;
        w = {$urandom, $urandom};
        return w[CFG-1:0];
    endfunction

    initial begin
        logic [CFG-1:0] cfg;
        int nb;
        crst = 1'b0;
        cfg_in_start = 1'b0;
        cfg_bit_in = 1'b0;
        cfg_bit_in_valid = 1'b0;
        north_in = '0;
        east_in = '0;
        south_in = '0;
        west_in = '0;
        rand_sides = 1'b1;
        commit_pending = 1'b0;
        model_active = '0;
        model_reg = '0;
        staged_cfg = '0;
        prev_start = 1'b0;
        prev_bit = 1'b0;
        prev_valid = 1'b0;

        applyReset();

        // North takes East on every bit, combinational.
        rand_sides = 1'b0;
        north_in = 4'h0;
        east_in = 4'hA;
        south_in = 4'h5;
        west_in = 4'h3;
        cfg = '0;
        cfg[7:0] = 8'h55;
        done_seen = 0;
        sendFrame(3'b101, cfg, CFG, 0, 0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("north_eq_east", out_c[0], 4'hA);
        checkOutput("east_zero", out_c[1], 4'h0);
        checkOutput("match_done_count", done_seen, 1);

        // Non-matching header leaves routing alone.
        rand_sides = 1'b1;
        done_seen = 0;
        sendFrame(3'b011, randCfg(), CFG, 0, 2);
        checkOutput("nomatch_done_count", done_seen, 0);

        // Aborted frame followed by a complete one.
        done_seen = 0;
        sendFrame(3'b101, randCfg(), 20, 0, 0);
        sendFrame(3'b101, randCfg(), CFG, 0, 2);
        checkOutput("abort_done_count", done_seen, 1);

        // West takes South, registered.
        rand_sides = 1'b0;
        north_in = 4'h6;
        east_in = 4'h9;
        south_in = 4'h0;
        west_in = 4'h2;
        cfg = '0;
        cfg[31:24] = 8'hFF;
        cfg[35] = 1'b1;
        sendFrame(3'b101, cfg, CFG, 0, 0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        south_in = 4'hF;
        #1;
        checkOutput("west_comb_same_cycle", out_c[3], 4'hF);
        checkOutput("west_reg_not_yet", out_r[3], 4'h0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("west_reg_next_cycle", out_r[3], 4'hF);

        // Gapped delivery of a matching frame.
        rand_sides = 1'b1;
        sendFrame(3'b101, randCfg(), CFG, 40, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Random mix of frames, aborts, gaps, back-to-back starts and resets.
        for (int n = 0; n < 60; n++) begin
            cfg = randCfg();
            nb = ($urandom_range(3) == 0) ? int'($urandom_range(CFG - 1)) : CFG;
            sendFrame(($urandom_range(9) < 6) ? IDW'(MYID) : IDW'($urandom),
                      cfg, nb, int'($urandom_range(50)), int'($urandom_range(3)));
            if ($urandom_range(19) == 0) applyReset();
            else repeat ($urandom_range(2)) applyStimulus(1'b0, 1'($urandom), 1'b0);
        end

        applyStimulus(1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sb_cfg_pipe.md
# sb_cfg_pipe

Parametrised four-sided switch box with an integrated serial configuration loader. Each output bit selects an input bit of the same track index from one of the other three sides, or constant 0. Each side can optionally register its output. Configuration arrives on the fabric's daisy-chained config bus: an ID-addressed frame loads a shadow register, and the active routing changes atomically at frame end. It is the next-generation switch-box tile, instantiated once per routing tile.

## Interface
Parameters:
- CHN_WIDTH, 16, tracks per side
- ID_WIDTH, 3, width of the frame header ID
- ID, 7, this block's chain address
- REG_OUT_EN, 1, builds per-side output flops. When 0, the mode bits are still loaded but ignored.
- Derived: CFG_SIZE = 8*CHN_WIDTH + 4

Ports:
- clk  in  1  single clock. Fabric datapath and config logic share this clock.
- crst  in  1  reset, synchronous, active-high
- north_in / east_in / south_in / west_in  in  CHN_WIDTH  side inputs
- north_out / east_out / south_out / west_out  out  CHN_WIDTH  side outputs
- cfg_in_start  in  1  frame start strobe
- cfg_bit_in  in  1  serial config data
- cfg_bit_in_valid  in  1  qualifies cfg_bit_in
- cfg_out_start, cfg_bit_out, cfg_bit_out_valid  out  1 each  registered copies of the three inputs, driven to the next block
- cfg_done  out  1  one-cycle pulse when the active config is updated

## Operation
- Side index s: N=0, E=1, S=2, W=3, in clockwise order.
- Select field for output side s, bit i: active[2*CHN_WIDTH*s + 2*i +: 2].
  - 0 → 1'b0
  - 1 → input side (s+1)%4
  - 2 → input side (s+2)%4
  - 3 → input side (s+3)%4
  - Example: N selects 1=E, 2=S, 3=W.
- Mode bit for side s: active[8*CHN_WIDTH + s]. 1 = output registered, 0 = combinational from the mux.
- Loader FSM states:
  - IDLE: on cfg_in_start → HDR, with bit count = 0.
  - HDR: each valid bit shifts MSB-first into id_sr. After ID_WIDTH valid bits, go to LOAD if id_sr equals ID, otherwise to SKIP.
  - LOAD: each valid bit is applied as shadow <= {shadow[CFG_SIZE-2:0], bit}; the first bit sent lands in active[CFG_SIZE-1]. After CFG_SIZE valid bits → COMMIT.
  - COMMIT: for one cycle, active <= shadow, cfg_done = 1, then → IDLE.
  - SKIP: ignore bits until the next cfg_in_start.
- cfg_in_start in any state (COMMIT included): restart HDR with count 0.
  - A partially loaded shadow is discarded.
  - active is unchanged.
  - Bits in the same cycle as cfg_in_start are ignored.
- Invalid cycles (cfg_bit_in_valid = 0) advance nothing.
- Chain forwarding is independent of FSM state. Every cycle the three cfg_* outputs register the three cfg_* inputs, so every block on the chain sees every frame.
- Bit counter width is $clog2(CFG_SIZE+1) and it never wraps. Frames longer than header + CFG_SIZE bits leave the trailing bits ignored, because the FSM is already in IDLE.

## Timing
- Reset (crst high at a clk edge):
  - active, shadow, id_sr, counter and output flops are cleared to 0.
  - FSM goes to IDLE.
  - cfg_out_start, cfg_bit_out, cfg_bit_out_valid and cfg_done are 0.
  - All side outputs are therefore 0 after reset.
  - Reset mid-frame aborts the frame; active is cleared.
- Combinational side: output changes in the same cycle as its input.
- Registered side: 1-cycle latency.
- Mode switch: takes effect from the cycle after the commit edge. The first registered value is the flop content, which updates every cycle regardless of mode.
- Commit: last payload bit sampled at edge k → COMMIT during cycle k+1 with cfg_done high → active updated at edge k+1. New routing is visible from cycle k+2; registered sides show it from cycle k+3.
- Chain forwarding latency: exactly 1 cycle per block.

## Structure
- Package sb_pkg holds:
  - side indices (N, E, S, W)
  - select codes (SEL_ZERO, SEL_CW1, SEL_CW2, SEL_CW3)
  - loader state enum (IDLE, HDR, LOAD, COMMIT, SKIP)
  - the CFG_SIZE function
- Sub-module cfg_loader contains the FSM, shift registers, active register and chain forwarding, parametrised by CFG_SIZE, ID_WIDTH and ID.
- The top level contains the four mux arrays (generate loops) and the optional output flops.

## Test plan
All scenarios use CHN_WIDTH=4, ID_WIDTH=3, ID=5, so CFG_SIZE=36.
- Reset: hold crst 2 cycles with nonzero inputs → all outputs 0, cfg_done 0, cfg_* outputs 0.
- Matching frame: send header 3'b101 and a payload routing N←E (all sels 1), combinational mode; drive east_in=4'hA → cfg_done pulses once, exactly 1 cycle after the last bit; north_out=4'hA from the following cycle; other outputs 0.
- Non-matching frame: send header 3'b011 plus 36 bits → active unchanged, no cfg_done; cfg_* outputs equal the inputs delayed 1 cycle throughout.
- Abort: cfg_in_start after 20 payload bits, then a complete matching frame → only the second frame's config is active; exactly one cfg_done pulse.
- Registered mode: set mode bit for W, W←S; step south_in 0→4'hF → west_out rises 1 cycle later. With REG_OUT_EN=0 the same frame gives a same-cycle rise.
- Gapped valid: insert random valid=0 cycles during the payload of the matching frame → result identical to the ungapped case.
